// File: rtl/nr_pkg.sv
// Shared types and helpers for the Newton-Raphson reciprocal unit.
package nr_pkg;

    localparam int unsigned NR_WIDTH = 16;
    localparam int unsigned NR_LZC_W = $clog2(NR_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NORM = 3'd1,
        ST_MUL1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_DONE = 3'd4
    } nr_state_e;

    // floor(2^(S+L) / (2^L + i + 0.5)), scaled by 2 to stay in integers
    function automatic int unsigned seed_f(input int unsigned i,
                                           input int unsigned lut_bits,
                                           input int unsigned seed_bits);
        return (32'd1 << (seed_bits + lut_bits + 1)) /
               ((32'd1 << (lut_bits + 1)) + (i << 1) + 32'd1);
    endfunction

endpackage

// File: rtl/nr_norm.sv
// Combinational normaliser: leading-zero count and left shift so the MSB is set.
module nr_norm
    import nr_pkg::*;
#(
    parameter  int unsigned WIDTH = NR_WIDTH,
    localparam int unsigned SW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] a_c,
    output logic [SW-1:0]    s_c,
    output logic             zero_c
);

    logic found;

    always_comb begin
        s_c   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && d_i[i]) begin
                s_c   = SW'(WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        zero_c = ~|d_i;
        a_c    = d_i << s_c;
    end

endmodule

// File: rtl/nr_recip_iter.sv
// Newton-Raphson reciprocal: normalise, LUT seed, ITERS refinements on one shared multiplier.
module nr_recip_iter
    import nr_pkg::*;
#(
    parameter  int unsigned WIDTH     = NR_WIDTH,
    parameter  int unsigned LUT_BITS  = 5,
    parameter  int unsigned SEED_BITS = 6,
    parameter  int unsigned ITERS     = 2,
    localparam int unsigned SW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [SW-1:0]    s_out,
    output logic             dz_out
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IW    = 3;
    localparam int unsigned LUT_N = 1 << LUT_BITS;

    nr_state_e         state_q, state_d;
    logic [IW-1:0]     it_q, it_d;
    logic [WIDTH-1:0]  d_q, d_d, a_q, a_d, x_q, x_d, t_q, t_d;
    logic [SW-1:0]     s_q, s_d;
    logic              dz_q, dz_d;
    logic              out_valid_q, out_valid_d, in_ready_q, in_ready_d, dz_out_q, dz_out_d;
    logic [WIDTH-1:0]  x_out_q, x_out_d;
    logic [SW-1:0]     s_out_q, s_out_d;

    logic [WIDTH-1:0]  norm_a;
    logic [SW-1:0]     norm_s;
    logic              norm_zero;
    logic [WIDTH-1:0]  seed_x;
    logic [SEED_BITS-1:0] seed_rom [LUT_N];
    logic [WIDTH-1:0]  mul_a, mul_b;
    logic [PW-1:0]     prod;
    logic [WIDTH:0]    e_full;
    logic [WIDTH-1:0]  e_sat;
    logic              prod_lo_unused;

    nr_norm #(.WIDTH(WIDTH)) u_norm (
        .d_i    (d_q),
        .a_c    (norm_a),
        .s_c    (norm_s),
        .zero_c (norm_zero)
    );

    for (genvar g = 0; g < LUT_N; g++) begin : g_seed
        assign seed_rom[g] = SEED_BITS'(seed_f(g, LUT_BITS, SEED_BITS));
    end

    assign seed_x = {seed_rom[norm_a[WIDTH-2 -: LUT_BITS]], {(WIDTH - SEED_BITS){1'b0}}};

    // Single multiplier shared by both NR half-steps
    assign prod           = PW'(mul_a) * PW'(mul_b);
    assign prod_lo_unused = ^prod[WIDTH-2:0];

    // Error term 2 - a*x, clamped so t==0 cannot wrap
    assign e_full = {1'b1, {WIDTH{1'b0}}} - {1'b0, t_q};
    assign e_sat  = e_full[WIDTH] ? '1 : e_full[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        it_d        = it_q;
        d_d         = d_q;
        a_d         = a_q;
        x_d         = x_q;
        t_d         = t_q;
        s_d         = s_q;
        dz_d        = dz_q;
        mul_a       = a_q;
        mul_b       = x_q;
        out_valid_d = out_valid_q;
        x_out_d     = x_out_q;
        s_out_d     = s_out_q;
        dz_out_d    = dz_out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    d_d     = d_in;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                a_d     = norm_a;
                s_d     = norm_s;
                dz_d    = norm_zero;
                x_d     = seed_x;
                it_d    = '0;
                state_d = (ITERS == 0) ? ST_DONE : ST_MUL1;
            end
            ST_MUL1: begin
                t_d     = prod[PW-1 -: WIDTH];
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                mul_a   = x_q;
                mul_b   = e_sat;
                x_d     = prod[PW-1] ? '1 : prod[PW-2 -: WIDTH];
                it_d    = it_q + IW'(1);
                state_d = (it_q + IW'(1) == IW'(ITERS)) ? ST_DONE : ST_MUL1;
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Result registers load once on the first DONE cycle and hold until taken
        if (state_q == ST_DONE) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                x_out_d     = dz_q ? '1 : x_q;
                s_out_d     = dz_q ? '0 : s_q;
                dz_out_d    = dz_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            it_q        <= '0;
            d_q         <= '0;
            a_q         <= '0;
            x_q         <= '0;
            t_q         <= '0;
            s_q         <= '0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            x_out_q     <= '0;
            s_out_q     <= '0;
            dz_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            it_q        <= it_d;
            d_q         <= d_d;
            a_q         <= a_d;
            x_q         <= x_d;
            t_q         <= t_d;
            s_q         <= s_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            x_out_q     <= x_out_d;
            s_out_q     <= s_out_d;
            dz_out_q    <= dz_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign s_out     = s_out_q;
    assign dz_out    = dz_out_q;

endmodule
